// File: rtl/subterranean_dout_serializer.sv
// -----------------------------------------------------------------------------
// subterranean_dout_serializer
//
// Splits each 64-bit output beat of the Subterranean duplex rounds block into
// up to two 32-bit lanes on a valid/ready stream. Each lane carries a byte
// count and a last-lane flag. Empty lanes are skipped and fully empty beats are
// dropped. A running count of emitted bytes is kept for the top-level
// controller.
//
// Ports:
//   clk        : clock, all logic on the rising edge
//   arstn      : synchronous active-high reset (1 = reset)
//   cnt_clear  : synchronous clear of byte_cnt (wins over a same-cycle transfer)
//   din        : input beat, lane0 = [31:0], lane1 = [63:32]
//   din_size   : [2:0] lane0 bytes, [5:3] lane1 bytes (codes 5..7 mean 4)
//   din_valid  : input beat valid
//   din_ready  : input beat accepted when din_valid & din_ready
//   dout       : output lane, byte 0 in [7:0]
//   dout_size  : valid bytes in dout (1..4 while dout_valid, else 0)
//   dout_last  : final non-empty lane of the beat
//   dout_valid : output valid
//   dout_ready : consumer ready
//   byte_cnt   : bytes transferred since reset/clear, wraps modulo 2^CNT_WIDTH
//
// Build option:
//   SUBTERRANEAN_DOUT_SERIALIZER_ZERO_MASK_EN - when defined, bytes of dout at
//   index >= dout_size are forced to 0x00 (dout is all zero while idle). When
//   undefined, unused bytes carry the raw lane content.
// -----------------------------------------------------------------------------
module subterranean_dout_serializer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 cnt_clear,
    input  logic [63:0]          din,
    input  logic [5:0]           din_size,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [31:0]          dout,
    output logic [2:0]           dout_size,
    output logic                 dout_last,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [CNT_WIDTH-1:0] byte_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LANE0 = 2'd1,
        LANE1 = 2'd2
    } state_t;

    state_t      state;

    // Lane0 is loaded straight into the output register on acceptance, so only
    // lane1 and its size need to be held for the second output cycle.
    logic [31:0] lane1_p0;
    logic [2:0]  size1_p0;
    logic [31:0] dout_p0;

    logic [2:0]  in_size0;
    logic [2:0]  in_size1;
    logic        xfer;
    logic        accept;
    logic        lane_final;

    // Size codes above 4 saturate to a full 4-byte lane.
    function automatic logic [2:0] norm_size(input logic [2:0] code);
        return (code > 3'd4) ? 3'd4 : code;
    endfunction

    assign in_size0 = norm_size(din_size[2:0]);
    assign in_size1 = norm_size(din_size[5:3]);

    assign xfer       = dout_valid & dout_ready;
    assign lane_final = (state == LANE1) || ((state == LANE0) && (size1_p0 == 3'd0));
    // A new beat may enter while the final lane leaves, giving back-to-back beats.
    assign din_ready  = (state == IDLE) || (lane_final && dout_ready);
    assign accept     = din_valid & din_ready;

    // Control: state, output qualifiers and byte counter.
    always_ff @(posedge clk) begin
        if (arstn) begin
            state      <= IDLE;
            dout_valid <= 1'b0;
            dout_size  <= 3'd0;
            dout_last  <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            if (cnt_clear) begin
                byte_cnt <= '0;
            end else if (xfer) begin
                byte_cnt <= byte_cnt + CNT_WIDTH'(dout_size);
            end

            if (accept) begin
                if (in_size0 != 3'd0) begin
                    state      <= LANE0;
                    dout_valid <= 1'b1;
                    dout_size  <= in_size0;
                    dout_last  <= (in_size1 == 3'd0);
                end else if (in_size1 != 3'd0) begin
                    state      <= LANE1;
                    dout_valid <= 1'b1;
                    dout_size  <= in_size1;
                    dout_last  <= 1'b1;
                end else begin
                    state      <= IDLE;
                    dout_valid <= 1'b0;
                    dout_size  <= 3'd0;
                    dout_last  <= 1'b0;
                end
            end else if (xfer) begin
                if ((state == LANE0) && (size1_p0 != 3'd0)) begin
                    state      <= LANE1;
                    dout_valid <= 1'b1;
                    dout_size  <= size1_p0;
                    dout_last  <= 1'b1;
                end else begin
                    state      <= IDLE;
                    dout_valid <= 1'b0;
                    dout_size  <= 3'd0;
                    dout_last  <= 1'b0;
                end
            end
        end
    end

    // Data: capture stage (p0), no reset needed since qualifiers gate it.
    always_ff @(posedge clk) begin
        if (accept) begin
            lane1_p0 <= din[63:32];
            size1_p0 <= in_size1;
            dout_p0  <= (in_size0 != 3'd0) ? din[31:0] : din[63:32];
        end else if (xfer && (state == LANE0)) begin
            dout_p0  <= lane1_p0;
        end
    end

`ifdef SUBTERRANEAN_DOUT_SERIALIZER_ZERO_MASK_EN
    function automatic logic [31:0] mask_lane(input logic [31:0] d, input logic [2:0] n);
        logic [31:0] m;
        m = d;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) >= n) m[8*i +: 8] = 8'h00;
        end
        return m;
    endfunction

    // dout_size is 0 while idle, so the mask also clears dout then.
    assign dout = mask_lane(dout_p0, dout_size);
`else
    assign dout = dout_p0;
`endif

endmodule

// File: doc/subterranean_dout_serializer.md
Name: subterranean_dout_serializer

Overview:
- Downstream of the two-round Subterranean duplex datapath.
- Consumes its 64-bit dout beat with the 6-bit two-lane size code and emits one 32-bit lane per cycle on a valid/ready stream, with a byte count per lane and a last-lane flag.
- Drops empty lanes.
- Keeps a running count of emitted bytes for the top-level controller (tag/ciphertext length checks).

Parameters:
- CNT_WIDTH, 16, width of the running emitted-byte counter byte_cnt.

Ports:
- clk  in  1  clock; all logic on rising edge.
- arstn  in  1  reset, synchronous, active-high (1 = reset); named as elsewhere in the codebase.
- cnt_clear  in  1  synchronous clear of byte_cnt.
- din  in  64  beat from rounds block: lane0 = [31:0], lane1 = [63:32].
- din_size  in  6  [2:0] = lane0 bytes, [5:3] = lane1 bytes; codes 0-4 literal, 5-7 treated as 4.
- din_valid  in  1  beat valid.
- din_ready  out  1  beat accepted when din_valid & din_ready.
- dout  out  32  lane data, byte 0 in [7:0].
- dout_size  out  3  valid bytes in dout, 1..4 while dout_valid; 0 otherwise.
- dout_last  out  1  high on final non-empty lane of the beat.
- dout_valid  out  1  output valid.
- dout_ready  in  1  consumer ready.
- byte_cnt  out  CNT_WIDTH  total bytes transferred since reset/clear.

Behaviour:
- Holding register: 64-bit data plus two 3-bit lane sizes, normalised (5-7 -> 4) at capture.
- FSM states:
  - IDLE: dout_valid=0, din_ready=1.
  - LANE0: presenting lane0.
  - LANE1: presenting lane1.
- Accepting a beat (from IDLE or by pass-through):
  - Goes to LANE0 if size0 != 0, else LANE1 if size1 != 0.
  - Otherwise the beat is dropped, state goes to IDLE and there is no output.
- Latency: first lane is valid the cycle after acceptance. No combinational path from din to dout.
- LANE0, dout_valid & dout_ready:
  - Goes to LANE1 if size1 != 0.
  - Otherwise the lane is final (dout_last=1) and the pass-through rule applies.
- LANE1: always final; dout_last=1.
- Pass-through: din_ready = 1 in IDLE, or in a final lane when dout_ready=1. This gives back-to-back beats with no bubble.
  - A beat accepted in the same cycle the final lane transfers is captured, and the next state follows the acceptance rule.
  - If the final lane transfers and no new beat arrives, the state goes to IDLE.
- Stall: while dout_valid=1 and dout_ready=0, dout, dout_size, dout_last and state hold stable.
- byte_cnt:
  - Each output transfer adds dout_size; the counter wraps modulo 2^CNT_WIDTH.
  - cnt_clear has priority over the increment and yields 0 in the same edge. A transfer in that cycle is not counted.
- Reset (arstn=1 at edge):
  - State IDLE, dout_valid=0, dout_size=0, dout_last=0, byte_cnt=0; din_ready=1 after reset.
  - A mid-operation reset discards the held beat.
  - dout data content is don't-care while dout_valid=0.

Optional Feature:
- SUBTERRANEAN_DOUT_SERIALIZER_ZERO_MASK_EN
  - Defined: bytes of dout at index >= dout_size are forced to 0x00, and dout is all zero when dout_valid=0.
  - Undefined: unused bytes carry the raw lane content (e.g. keystream bytes); lower area.

Test Plan:
- Reset, then din=64'h8877665544332211_DDCCBBAA..., din_size=6'b100_011 -> cycle+1: dout=lane0, dout_size=3, dout_last=0; after ready: dout=32'h88776655, dout_size=4, dout_last=1; byte_cnt=7.
- din_size=6'b000_100 (absorb-with-output, low lane) -> single lane, dout_size=4, dout_last=1; din_size=6'b100_000 -> only lane1 emitted, dout_size=4, dout_last=1.
- din_size=0 with din_valid=1 -> beat accepted, no dout_valid ever, byte_cnt unchanged.
- Back-to-back full beats (size 6'b100_100) with dout_ready=1 constant -> dout_valid continuous, din_ready high every second cycle, byte_cnt +4 per cycle; hold dout_ready=0 for 3 cycles -> outputs stable, din_ready=0.
- din_size=6'b111_101 -> both lanes reported as 4 bytes. With ZERO_MASK_EN and size code 1: dout=32'h000000AA.
- Assert arstn mid-LANE0 -> next cycle dout_valid=0, byte_cnt=0. cnt_clear coincident with transfer -> byte_cnt=0.
